// File: rtl/dmaburst_pkg.sv
// dmaburst_pkg: shared constants and types for the dmaburst block-DMA sequencer.
//   - ARM-side register indices and the ID value
//   - downstream (switch/light DMA port) register indices and go bit position
//   - sequencer state enum
//   - 16-bit end-around-carry add used by the optional checksum
package dmaburst_pkg;

  localparam logic [2:0] REG_ID    = 3'd0;
  localparam logic [2:0] REG_CTRL  = 3'd1;
  localparam logic [2:0] REG_IDX   = 3'd2;
  localparam logic [2:0] REG_DATA  = 3'd3;
  localparam logic [2:0] REG_FAIL  = 3'd4;
  localparam logic [2:0] REG_CKSUM = 3'd5;

  localparam logic [31:0] ID_VALUE = 32'h44422001;
  localparam logic [31:0] BAD_REG  = 32'hDEADBEEF;

  localparam logic [2:0]  SL_DMACTL  = 3'd3;
  localparam logic [2:0]  SL_DMADATA = 3'd4;
  localparam int unsigned GO_BIT     = 29;

  typedef enum logic [3:0] {
    IDLE, LOAD, START, SETTLE, POLL, CAPTURE, NEXT, FAIL, DONE
  } state_e;

  // One's-complement style sum: carry out of bit 15 folds back into bit 0.
  function automatic logic [15:0] eac_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'b0, s[16]};
  endfunction

endpackage

// File: rtl/dmaburst_buf.sv
// dmaburst_buf: BUFWORDS x 16-bit register file for the burst buffer.
// Ports:
//   CLOCK                                   clock
//   arm_we/arm_addr/arm_wdata/arm_rdata     ARM-side access (write + async read)
//   seq_we/seq_addr/seq_wdata/seq_rdata     sequencer access (write + async read)
// ARM writes are only issued while idle and sequencer writes only while busy, so a
// write collision cannot happen; the sequencer is still given priority.
module dmaburst_buf #(
  parameter int unsigned BUFWORDS = 16
) (
  input  logic        CLOCK,
  input  logic        arm_we,
  input  logic [3:0]  arm_addr,
  input  logic [15:0] arm_wdata,
  output logic [15:0] arm_rdata,
  input  logic        seq_we,
  input  logic [3:0]  seq_addr,
  input  logic [15:0] seq_wdata,
  output logic [15:0] seq_rdata
);

  localparam int unsigned AW = (BUFWORDS > 1) ? $clog2(BUFWORDS) : 1;

  logic [15:0] mem_q [BUFWORDS];

  always_ff @(posedge CLOCK) begin
    if (seq_we) begin
      mem_q[seq_addr[AW-1:0]] <= seq_wdata;
    end else if (arm_we) begin
      mem_q[arm_addr[AW-1:0]] <= arm_wdata;
    end
  end

  assign arm_rdata = mem_q[arm_addr[AW-1:0]];
  assign seq_rdata = mem_q[seq_addr[AW-1:0]];

endmodule

// File: rtl/dmaburst.sv
// dmaburst: ARM-facing block-DMA sequencer in front of the single-word Unibus DMA
// register port. Moves 1..BUFWORDS words between an internal buffer and consecutive
// Unibus addresses by driving downstream reg 3 (ctrl/addr/status) and reg 4 (data).
// Ports:
//   CLOCK, RESET (synchronous, active-high)
//   armwrite/armwaddr/armwdata      ARM register write
//   armraddr/armrdata               ARM register read (combinational)
//   sl_own                          this block owns the downstream port
//   sl_armwrite/waddr/wdata         downstream write (registered)
//   sl_armraddr/sl_armrdata         downstream read index (registered) / read data
// Build option: DMABURST_CKSUM_EN adds an end-around-carry checksum at reg 5.
module dmaburst
  import dmaburst_pkg::*;
#(
  parameter int unsigned BUFWORDS = 16,
  parameter int unsigned TMOCYC   = 4095
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [2:0]  armwaddr,
  input  logic [2:0]  armraddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  output logic        sl_own,
  output logic        sl_armwrite,
  output logic [2:0]  sl_armwaddr,
  output logic [31:0] sl_armwdata,
  output logic [2:0]  sl_armraddr,
  input  logic [31:0] sl_armrdata
);

  localparam logic [3:0] IDX_MASK = 4'(BUFWORDS - 1);

  state_e      state_q, state_d;
  logic        dir_q, dir_d, busy_q, busy_d, fail_q, fail_d, abort_q, abort_d;
  logic [3:0]  cnt_q, cnt_d, idx_q, idx_d, widx_q, widx_d, fail_idx_q, fail_idx_d;
  logic [17:0] addr_q, addr_d, fail_addr_q, fail_addr_d;
  logic [15:0] tmo_q, tmo_d;
  logic        own_q, own_d, slw_q, slw_d;
  logic [2:0]  slwa_q, slwa_d, slra_q, slra_d;
  logic [31:0] slwd_q, slwd_d;
  logic        start_req, arm_we, seq_we;
  logic [15:0] arm_rdata, seq_rdata;
`ifdef DMABURST_CKSUM_EN
  logic [15:0] sum_q, sum_d;
`endif

  dmaburst_buf #(.BUFWORDS(BUFWORDS)) u_buf (
    .CLOCK     (CLOCK),
    .arm_we    (arm_we),
    .arm_addr  (idx_q),
    .arm_wdata (armwdata[15:0]),
    .arm_rdata (arm_rdata),
    .seq_we    (seq_we),
    .seq_addr  (widx_q),
    .seq_wdata (sl_armrdata[15:0]),
    .seq_rdata (seq_rdata)
  );

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    busy_d      = busy_q;
    fail_d      = fail_q;
    abort_d     = abort_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    widx_d      = widx_q;
    fail_idx_d  = fail_idx_q;
    addr_d      = addr_q;
    fail_addr_d = fail_addr_q;
    tmo_d       = tmo_q;
    own_d       = own_q;
    slw_d       = 1'b0;
    slwa_d      = slwa_q;
    slwd_d      = slwd_q;
    slra_d      = slra_q;
    start_req   = 1'b0;
    arm_we      = 1'b0;
    seq_we      = 1'b0;
`ifdef DMABURST_CKSUM_EN
    sum_d       = sum_q;
`endif

    // ARM register side
    if (armwrite) begin
      case (armwaddr)
        REG_CTRL: begin
          if (!busy_q && armwdata[31]) start_req = 1'b1;
          else if (busy_q && armwdata[28]) abort_d = 1'b1;
        end
        REG_IDX:  idx_d = armwdata[3:0] & IDX_MASK;
        REG_DATA: begin
          if (!busy_q) begin
            arm_we = 1'b1;
            idx_d  = (idx_q + 4'd1) & IDX_MASK;
          end
        end
        default: ;
      endcase
    end else if (armraddr == REG_DATA) begin
      // A data read auto-advances the index so the buffer can be streamed out.
      idx_d = (idx_q + 4'd1) & IDX_MASK;
    end

    if (start_req) begin
      dir_d   = armwdata[29];
      cnt_d   = armwdata[27:24];
      addr_d  = {armwdata[17:1], 1'b0};
      fail_d  = 1'b0;
      idx_d   = 4'd0;
      widx_d  = 4'd0;
      busy_d  = 1'b1;
      abort_d = 1'b0;
`ifdef DMABURST_CKSUM_EN
      sum_d   = 16'd0;
`endif
    end

    unique case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d = LOAD;
          own_d   = 1'b1;
        end
      end
      LOAD: begin
        if (dir_q) begin
          slw_d  = 1'b1;
          slwa_d = SL_DMADATA;
          slwd_d = {16'b0, seq_rdata};
`ifdef DMABURST_CKSUM_EN
          sum_d  = eac_add(sum_q, seq_rdata);
`endif
        end
        state_d = START;
      end
      START: begin
        slw_d         = 1'b1;
        slwa_d        = SL_DMACTL;
        // dmactrl[25:24] = 10 for write to Unibus, 00 for read.
        slwd_d        = {6'b0, dir_q, 1'b0, 6'b0, addr_q};
        slwd_d[GO_BIT] = 1'b1;
        slra_d        = SL_DMACTL;
        tmo_d         = 16'd0;
        state_d       = SETTLE;
      end
      SETTLE: state_d = POLL;
      POLL: begin
        if (sl_armrdata[31:29] == 3'd0) begin
          if (sl_armrdata[28]) begin
            state_d = FAIL;
          end else if (!dir_q) begin
            slra_d  = SL_DMADATA;
            state_d = CAPTURE;
          end else begin
            state_d = NEXT;
          end
        end else if (tmo_q == 16'(TMOCYC)) begin
          state_d = FAIL;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      CAPTURE: begin
        seq_we  = 1'b1;
`ifdef DMABURST_CKSUM_EN
        sum_d   = eac_add(sum_q, sl_armrdata[15:0]);
`endif
        state_d = NEXT;
      end
      NEXT: begin
        if (cnt_q == 4'd0 || abort_q) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          widx_d  = (widx_q + 4'd1) & IDX_MASK;
          addr_d  = addr_q + 18'd2;
          state_d = LOAD;
        end
      end
      FAIL: begin
        fail_d      = 1'b1;
        fail_idx_d  = widx_q;
        fail_addr_d = addr_q;
        state_d     = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        own_d   = 1'b0;
        abort_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      busy_q      <= 1'b0;
      fail_q      <= 1'b0;
      abort_q     <= 1'b0;
      cnt_q       <= 4'd0;
      idx_q       <= 4'd0;
      widx_q      <= 4'd0;
      fail_idx_q  <= 4'd0;
      addr_q      <= 18'd0;
      fail_addr_q <= 18'd0;
      tmo_q       <= 16'd0;
      own_q       <= 1'b0;
      slw_q       <= 1'b0;
      slwa_q      <= 3'd0;
      slwd_q      <= 32'd0;
      slra_q      <= 3'd0;
`ifdef DMABURST_CKSUM_EN
      sum_q       <= 16'd0;
`endif
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      fail_q      <= fail_d;
      abort_q     <= abort_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      widx_q      <= widx_d;
      fail_idx_q  <= fail_idx_d;
      addr_q      <= addr_d;
      fail_addr_q <= fail_addr_d;
      tmo_q       <= tmo_d;
      own_q       <= own_d;
      slw_q       <= slw_d;
      slwa_q      <= slwa_d;
      slwd_q      <= slwd_d;
      slra_q      <= slra_d;
`ifdef DMABURST_CKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign sl_own      = own_q;
  assign sl_armwrite = slw_q;
  assign sl_armwaddr = slwa_q;
  assign sl_armwdata = slwd_q;
  assign sl_armraddr = slra_q;

  always_comb begin
    armrdata = BAD_REG;
    case (armraddr)
      REG_ID:    armrdata = ID_VALUE;
      REG_CTRL:  armrdata = {busy_q, fail_q, dir_q, abort_q, cnt_q, 6'b0, addr_q};
      REG_IDX:   armrdata = {28'b0, idx_q};
      REG_DATA:  armrdata = {16'b0, arm_rdata};
      REG_FAIL:  armrdata = {fail_idx_q, 10'b0, fail_addr_q};
`ifdef DMABURST_CKSUM_EN
      REG_CKSUM: armrdata = {16'b0, sum_q};
`else
      REG_CKSUM: armrdata = BAD_REG;
`endif
      default:   armrdata = BAD_REG;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{armwdata[30], armwdata[23:18], sl_armrdata[27:16]};

endmodule

// File: tb/tb_dmaburst.sv
// tb_dmaburst: directed self-checking bench for dmaburst with a small behavioural
// model of the downstream single-word DMA port (reg 3 status, reg 4 data).
module tb_dmaburst;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        armwrite;
  logic [2:0]  armwaddr, armraddr;
  logic [31:0] armwdata, armrdata;
  logic        sl_own, sl_armwrite;
  logic [2:0]  sl_armwaddr, sl_armraddr;
  logic [31:0] sl_armwdata, sl_armrdata;

  int errors = 0;
  int checks = 0;

  always #5 CLOCK = ~CLOCK;

  dmaburst #(.BUFWORDS(16), .TMOCYC(15)) dut (
    .CLOCK       (CLOCK),
    .RESET       (RESET),
    .armwrite    (armwrite),
    .armwaddr    (armwaddr),
    .armraddr    (armraddr),
    .armwdata    (armwdata),
    .armrdata    (armrdata),
    .sl_own      (sl_own),
    .sl_armwrite (sl_armwrite),
    .sl_armwaddr (sl_armwaddr),
    .sl_armwdata (sl_armwdata),
    .sl_armraddr (sl_armraddr),
    .sl_armrdata (sl_armrdata)
  );

  // Downstream model: a go write to reg 3 makes dmastate nonzero for a few cycles
  // (or forever when stuck); reads complete with data 0o1000 + go number.
  logic        mdl_clear = 1'b0;
  logic        mdl_stuck = 1'b0;
  int          mdl_fail_on = -1;
  logic [2:0]  ds_state;
  logic        ds_fail, ds_rd;
  logic [15:0] ds_data;
  int          ds_lat, ds_gn, ds_goes;
  logic [2:0]  log_waddr [64];
  logic [31:0] log_wdata [64];
  int          log_n;

  always @(posedge CLOCK) begin
    if (RESET || mdl_clear) begin
      ds_state <= 3'd0; ds_fail <= 1'b0; ds_rd <= 1'b0; ds_data <= 16'd0;
      ds_lat <= 0; ds_gn <= 0; ds_goes <= 0; log_n <= 0;
    end else if (sl_armwrite) begin
      if (log_n < 64) begin
        log_waddr[log_n] <= sl_armwaddr;
        log_wdata[log_n] <= sl_armwdata;
        log_n <= log_n + 1;
      end
      if (sl_armwaddr == 3'd4) ds_data <= sl_armwdata[15:0];
      if (sl_armwaddr == 3'd3 && sl_armwdata[29]) begin
        ds_state <= mdl_stuck ? 3'd4 : 3'd1;
        ds_fail  <= 1'b0;
        ds_lat   <= 2;
        ds_rd    <= ~sl_armwdata[25];
        ds_gn    <= ds_goes;
        ds_goes  <= ds_goes + 1;
      end
    end else if (ds_state != 3'd0 && !mdl_stuck) begin
      if (ds_lat == 0) begin
        ds_state <= 3'd0;
        ds_fail  <= (ds_gn == mdl_fail_on);
        if (ds_rd) ds_data <= 16'o1000 + 16'(ds_gn);
      end else begin
        ds_lat <= ds_lat - 1;
      end
    end
  end

  always_comb begin
    sl_armrdata = 32'd0;
    if (sl_armraddr == 3'd3) sl_armrdata = {ds_state, ds_fail, 28'd0};
    else if (sl_armraddr == 3'd4) sl_armrdata = {16'd0, ds_data};
  end

  function automatic logic [31:0] start_word(input logic dir, input logic [3:0] cnt,
                                             input logic [17:0] addr);
    return 32'h8000_0000 | (32'(dir) << 29) | (32'(cnt) << 24) | 32'(addr);
  endfunction

  function automatic logic [31:0] go_word(input logic dir, input logic [17:0] addr);
    return 32'h2000_0000 | (32'(dir) << 25) | 32'(addr);
  endfunction

  task automatic arm_wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge CLOCK); armwrite = 1'b1; armwaddr = a; armwdata = d;
    @(negedge CLOCK); armwrite = 1'b0; armwaddr = 3'd0; armwdata = 32'd0;
  endtask

  task automatic arm_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge CLOCK); armraddr = a;
    #1 d = armrdata;
    @(negedge CLOCK); armraddr = 3'd0;
  endtask

  task automatic clr_model();
    @(negedge CLOCK); mdl_clear = 1'b1;
    @(negedge CLOCK); mdl_clear = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    @(negedge CLOCK); armraddr = 3'd1;
    #1;
    while (armrdata[31] && k < 500) begin
      @(negedge CLOCK); #1; k++;
    end
    checks++;
    if (armrdata[31] !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%0b after %0d cycles, required 0", name, armrdata[31], k);
    end
    armraddr = 3'd0;
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    RESET = 1'b1; armwrite = 1'b0; armwaddr = 3'd0; armraddr = 3'd0; armwdata = 32'd0;
    repeat (3) @(negedge CLOCK);
    checks++;
    if ({sl_own, sl_armwrite, sl_armwaddr, sl_armraddr} !== 8'd0 || sl_armwdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_sl: own=%b wr=%b wa=%0d ra=%0d wd=%h, required all 0",
               sl_own, sl_armwrite, sl_armwaddr, sl_armraddr, sl_armwdata);
    end
    RESET = 1'b0;
    arm_rd(3'd0, rd); check32("reset_id", rd, 32'h44422001);
    arm_rd(3'd1, rd); check32("reset_status", rd, 32'h0);
    arm_rd(3'd2, rd); check32("reset_idx", rd, 32'h0);
    arm_rd(3'd6, rd); check32("reset_reg6", rd, 32'hDEADBEEF);
`ifndef DMABURST_CKSUM_EN
    arm_rd(3'd5, rd); check32("reset_reg5", rd, 32'hDEADBEEF);
`endif
  endtask

  task automatic test_read_burst();
    logic [31:0] rd;
    clr_model();
    arm_wr(3'd1, start_word(1'b0, 4'd3, 18'o1000));
    wait_idle("rdburst");
    check32("rdburst_count", 32'(log_n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check32("rdburst_go_addr", {29'd0, log_waddr[i]}, 32'd3);
      check32("rdburst_go_word", log_wdata[i], go_word(1'b0, 18'o1000 + 18'(2 * i)));
    end
    arm_rd(3'd1, rd); check32("rdburst_status", rd, 32'o1006);
    arm_wr(3'd2, 32'd0);
    for (int i = 0; i < 4; i++) begin
      arm_rd(3'd3, rd); check32("rdburst_buf", rd, 32'o1000 + 32'(i));
    end
    arm_rd(3'd2, rd); check32("rdburst_idx_after_reads", rd, 32'd4);
`ifdef DMABURST_CKSUM_EN
    arm_rd(3'd5, rd); check32("rdburst_cksum", rd, 32'h0806);
`endif
  endtask

  task automatic test_write_burst();
    logic [31:0] rd;
    clr_model();
    arm_wr(3'd2, 32'd0);
    arm_wr(3'd3, 32'h1111);
    arm_wr(3'd3, 32'h2222);
    arm_wr(3'd1, start_word(1'b1, 4'd1, 18'o2000));
    wait_idle("wrburst");
    check32("wrburst_count", 32'(log_n), 32'd4);
    check32("wrburst_w0_idx", {29'd0, log_waddr[0]}, 32'd4);
    check32("wrburst_w0_data", log_wdata[0], 32'h1111);
    check32("wrburst_w1_idx", {29'd0, log_waddr[1]}, 32'd3);
    check32("wrburst_w1_go", log_wdata[1], go_word(1'b1, 18'o2000));
    check32("wrburst_w2_idx", {29'd0, log_waddr[2]}, 32'd4);
    check32("wrburst_w2_data", log_wdata[2], 32'h2222);
    check32("wrburst_w3_go", log_wdata[3], go_word(1'b1, 18'o2002));
    arm_rd(3'd1, rd); check32("wrburst_status", rd, 32'h2000_0000 | 32'o2002);
`ifdef DMABURST_CKSUM_EN
    arm_rd(3'd5, rd); check32("wrburst_cksum", rd, 32'h3333);
`endif
  endtask

  task automatic test_fail();
    logic [31:0] rd;
    clr_model();
    mdl_fail_on = 2;
    arm_wr(3'd1, start_word(1'b0, 4'd3, 18'o3000));
    wait_idle("fail");
    mdl_fail_on = -1;
    check32("fail_go_count", 32'(log_n), 32'd3);
    arm_rd(3'd1, rd); check32("fail_status", rd, 32'h4100_0000 | 32'o3004);
    arm_rd(3'd4, rd); check32("fail_info", rd, 32'h2000_0000 | 32'o3004);
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    int k, n;
    clr_model();
    mdl_stuck = 1'b1;
    arm_wr(3'd1, start_word(1'b0, 4'd0, 18'o4000));
    k = 0;
    while (!(sl_armwrite && sl_armwaddr == 3'd3) && k < 50) begin
      @(negedge CLOCK); k++;
    end
    n = 0;
    while (sl_own && n < 100) begin
      @(negedge CLOCK); n++;
    end
    check32("timeout_settle_to_release", 32'(n), 32'd19);
    mdl_stuck = 1'b0;
    wait_idle("timeout");
    arm_rd(3'd1, rd); check32("timeout_status", rd, 32'h4000_0000 | 32'o4000);
    arm_rd(3'd4, rd); check32("timeout_info", rd, 32'o4000);
  endtask

  task automatic test_wrap_abort();
    logic [31:0] rd;
    clr_model();
    arm_wr(3'd1, start_word(1'b0, 4'd2, 18'o777776));
    arm_wr(3'd1, 32'h1000_0000);
    wait_idle("abort");
    check32("abort_go_count", 32'(log_n), 32'd1);
    check32("abort_go_word", log_wdata[0], go_word(1'b0, 18'o777776));
    arm_rd(3'd1, rd); check32("abort_status", rd, 32'h0200_0000 | 32'o777776);
    clr_model();
    arm_wr(3'd1, start_word(1'b0, 4'd1, 18'o777776));
    wait_idle("wrap");
    check32("wrap_go_count", 32'(log_n), 32'd2);
    check32("wrap_go1_word", log_wdata[1], go_word(1'b0, 18'd0));
    arm_rd(3'd1, rd); check32("wrap_status", rd, 32'h0);
    arm_wr(3'd2, 32'd1);
    arm_rd(3'd3, rd); check32("wrap_buf1", rd, 32'o1001);
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd;
    int k;
    clr_model();
    mdl_stuck = 1'b1;
    arm_wr(3'd1, start_word(1'b0, 4'd0, 18'o4400));
    k = 0;
    while (!(sl_armwrite && sl_armwaddr == 3'd3) && k < 50) begin
      @(negedge CLOCK); k++;
    end
    repeat (3) @(negedge CLOCK);
    RESET = 1'b1;
    @(negedge CLOCK);
    RESET = 1'b0;
    mdl_stuck = 1'b0;
    checks++;
    if (sl_own !== 1'b0) begin
      errors++;
      $display("FAIL midreset_own: got %b, required 0", sl_own);
    end
    arm_rd(3'd1, rd); check32("midreset_status", rd, 32'h0);
    arm_wr(3'd1, start_word(1'b0, 4'd0, 18'o5000));
    wait_idle("midreset_restart");
    check32("midreset_go_count", 32'(log_n), 32'd1);
    check32("midreset_go_word", log_wdata[0], go_word(1'b0, 18'o5000));
    arm_rd(3'd1, rd); check32("midreset_restart_status", rd, 32'o5000);
    arm_rd(3'd3, rd); check32("midreset_buf0", rd, 32'o1000);
  endtask

  initial begin
    test_reset();
    test_read_burst();
    test_write_burst();
    test_fail();
    test_timeout();
    test_wrap_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
